aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_round_ctrl_if.sv | 26 ++
 rtl/round_counter.sv | 39 +++
 rtl/aes_round_ctrl.sv | 96 +++++++++
 tb/tb_aes_round_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
package aes_pkg;

  localparam int unsigned K_128   = 128;
  localparam int unsigned K_192   = 192;
  localparam int unsigned K_256   = 256;
  localparam int unsigned ROUND_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_ROUND,
    ST_DONE
  } aes_state_e;

  // Number of rounds for a given key length: 10, 12 or 14.
  function automatic int unsigned nr_of(input int unsigned k);
    return k / 32 + 6;
  endfunction

  function automatic bit k_is_legal(input int unsigned k);
    return (k == K_128) || (k == K_192) || (k == K_256);
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round controller and its user.
interface aes_round_ctrl_if;

  logic                         start;
  logic                         ack;
  logic                         abort;
  logic                         ready;
  logic                         expReset;
  logic                         expHold;
  logic                         loadState;
  logic [aes_pkg::ROUND_W-1:0]  round;
  logic                         firstRound;
  logic                         lastRound;
  logic                         done;

  modport master (
    output start, ack, abort,
    input  ready, expReset, expHold, loadState, round, firstRound, lastRound, done
  );

  modport slave (
    input  start, ack, abort,
    output ready, expReset, expHold, loadState, round, firstRound, lastRound, done
  );

endinterface

// File: rtl/round_counter.sv
// Saturating round counter: clears to 0, counts up while enabled, stops at NR.
module round_counter
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [ROUND_W-1:0] cnt_o,
  output logic               term_o
);

  logic [ROUND_W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == ROUND_W'(NR));
  assign cnt_o  = cnt_q;

  // Next count: clear wins, otherwise advance until the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + ROUND_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE -> INIT -> LOAD -> ROUND x (Nr+1) -> DONE.
// All outputs decode from the state and counter registers only.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned K = K_128
) (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.slave  bus
);

  localparam int unsigned NR = nr_of(K);

  if (!k_is_legal(K)) begin : g_illegal_k
    $error("aes_round_ctrl: K must be 128, 192 or 256");
  end

  aes_state_e         state_q, state_d;
  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_term;
  logic [ROUND_W-1:0] cnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; abort overrides every other transition outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_INIT;
      ST_INIT:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ROUND;
      ST_ROUND: if (cnt_term) state_d = ST_DONE;
      ST_DONE:  if (bus.ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Counter is held at 0 whenever we are not staying in ROUND, so it
  // enters ROUND at 0 and is cleared again on abort or on leaving.
  assign cnt_clr = (state_q != ST_ROUND) || (state_d != ST_ROUND);
  assign cnt_en  = (state_q == ST_ROUND);

  round_counter #(
    .NR (NR)
  ) u_round_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  // Output decode from registered state and count.
  always_comb begin
    bus.ready      = 1'b0;
    bus.expReset   = 1'b0;
    bus.expHold    = 1'b0;
    bus.loadState  = 1'b0;
    bus.round      = '0;
    bus.firstRound = 1'b0;
    bus.lastRound  = 1'b0;
    bus.done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.ready   = 1'b1;
        bus.expHold = 1'b1;
      end
      ST_INIT:  bus.expReset  = 1'b1;
      ST_LOAD:  bus.loadState = 1'b1;
      ST_ROUND: begin
        bus.round      = cnt;
        bus.firstRound = (cnt == '0);
        bus.lastRound  = cnt_term;
      end
      ST_DONE: begin
        bus.done    = 1'b1;
        bus.expHold = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl at K=128/192/256 driven in lockstep.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  typedef logic [12:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  aes_round_ctrl_if bus128();
  aes_round_ctrl_if bus192();
  aes_round_ctrl_if bus256();

  aes_round_ctrl #(.K(128)) dut128 (.clk(clk), .reset(reset), .bus(bus128));
  aes_round_ctrl #(.K(192)) dut192 (.clk(clk), .reset(reset), .bus(bus192));
  aes_round_ctrl #(.K(256)) dut256 (.clk(clk), .reset(reset), .bus(bus256));

  always #5 clk = ~clk;

  // {ready, expReset, expHold, loadState, round[3:0], firstRound, lastRound, done}
  logic [2:0][12:0] obs;
  assign obs[0] = {bus128.ready, bus128.expReset, bus128.expHold, bus128.loadState,
                   bus128.round, bus128.firstRound, bus128.lastRound, bus128.done};
  assign obs[1] = {bus192.ready, bus192.expReset, bus192.expHold, bus192.loadState,
                   bus192.round, bus192.firstRound, bus192.lastRound, bus192.done};
  assign obs[2] = {bus256.ready, bus256.expReset, bus256.expHold, bus256.loadState,
                   bus256.round, bus256.firstRound, bus256.lastRound, bus256.done};

  int unsigned nr_m [3] = '{10, 12, 14};
  int unsigned t_m  [3];
  int unsigned lat_m[3];
  bit          lat_on[3];
  bit          prev_done[3];
  vec_t        exp_q[$];
  int unsigned n_checks;
  int unsigned n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs t cycles after an accepted start (t=0 means idle).
  function automatic vec_t exp_vec(input int unsigned t, input int unsigned nr);
    logic r, er, eh, ls, fr, lr, dn;
    logic [3:0] rd;
    {r, er, eh, ls, fr, lr, dn} = '0;
    rd = '0;
    if (t == 0) begin
      r = 1'b1; eh = 1'b1;
    end else if (t == 1) begin
      er = 1'b1;
    end else if (t == 2) begin
      ls = 1'b1;
    end else if (t <= nr + 3) begin
      rd = 4'(t - 3);
      fr = (t == 3);
      lr = (t == nr + 3);
    end else begin
      dn = 1'b1; eh = 1'b1;
    end
    return {r, er, eh, ls, rd, fr, lr, dn};
  endfunction

  task automatic set_in(input logic s, input logic a, input logic ab);
    bus128.start = s; bus128.ack = a; bus128.abort = ab;
    bus192.start = s; bus192.ack = a; bus192.abort = ab;
    bus256.start = s; bus256.ack = a; bus256.abort = ab;
  endtask

  // One clock: drive inputs, push expectations, then pop and compare.
  task automatic step(input logic s, input logic a, input logic ab);
    vec_t e;
    @(negedge clk);
    set_in(s, a, ab);
    for (int i = 0; i < 3; i++) begin
      if (t_m[i] == 0) begin
        if (s) begin
          t_m[i] = 1; lat_m[i] = 0; lat_on[i] = 1'b1;
        end
      end else if (ab) begin
        t_m[i] = 0; lat_on[i] = 1'b0;
      end else if (t_m[i] < nr_m[i] + 4) begin
        t_m[i]++;
      end else if (a) begin
        t_m[i] = 0;
      end
      if (lat_on[i]) lat_m[i]++;
      exp_q.push_back(exp_vec(t_m[i], nr_m[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check_eq($sformatf("k%0d_outputs", 128 + 64 * i), 32'(obs[i]), 32'(e));
      if (obs[i][0] && !prev_done[i]) begin
        check_eq($sformatf("k%0d_latency", 128 + 64 * i), lat_m[i], nr_m[i] + 4);
        lat_on[i] = 1'b0;
      end
      prev_done[i] = obs[i][0];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_k%0d", tag, 128 + 64 * i), 32'(obs[i]), 32'(exp_vec(0, nr_m[i])));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 3; i++) begin
      t_m[i] = 0; lat_m[i] = 0; lat_on[i] = 1'b0; prev_done[i] = 1'b0;
    end
    set_in(1'b0, 1'b0, 1'b0);
    #1;
    check_reset_vals("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Quiet after reset, abort while idle has no effect
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Full run, done held while ack stays low, then ack
    step(1'b1, 1'b0, 1'b0);
    repeat (24) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Abort at round 5
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Restart; ack while busy ignored; start held through rounds; start with ack in DONE
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    repeat (16) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Abort in INIT, then abort in DONE
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-ROUND, seen before the next edge
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    for (int i = 0; i < 3; i++) begin
      t_m[i] = 0; lat_on[i] = 1'b0; prev_done[i] = 1'b0;
    end
    #3;
    @(negedge clk);
    reset = 1'b0;

    // Recovery run
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
